// File: rtl/axi_grid_router_in_port.sv
// Grid router input port: FIFO buffer with XY dimension-order routing of the head flit.
// The head flit is broadcast on flit_o; valid_o raises exactly one direction request.
module axi_grid_router_in_port #(
    parameter int unsigned X_W       = 4,
    parameter int unsigned Y_W       = 4,
    parameter int unsigned PAYLOAD_W = 64,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned MY_X      = 0,
    parameter int unsigned MY_Y      = 0,
    localparam int unsigned FLIT_W   = X_W + Y_W + PAYLOAD_W,
    localparam int unsigned AW       = $clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic              clk_i,
    input  logic              arst_ni,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [FLIT_W-1:0] flit_o,
    output logic [4:0]        valid_o,
    input  logic [4:0]        ready_i,
    output logic [CW-1:0]     count_o
);

    localparam logic [X_W-1:0] MY_X_L = X_W'(MY_X);
    localparam logic [Y_W-1:0] MY_Y_L = Y_W'(MY_Y);

    logic [FLIT_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [FLIT_W-1:0] w_head;
    logic [X_W-1:0]    w_dst_x;
    logic [Y_W-1:0]    w_dst_y;
    logic [4:0]        w_route;
    logic              w_push;
    logic              w_pop;

    assign w_head  = r_mem[r_rd_ptr];
    assign w_dst_x = w_head[FLIT_W-1 -: X_W];
    assign w_dst_y = w_head[FLIT_W-X_W-1 -: Y_W];

    // X is resolved fully before Y; bit order E, W, N, S, L.
    always_comb begin
        w_route = 5'b00000;
        if (w_dst_x > MY_X_L) begin
            w_route[0] = 1'b1;
        end else if (w_dst_x < MY_X_L) begin
            w_route[1] = 1'b1;
        end else if (w_dst_y > MY_Y_L) begin
            w_route[2] = 1'b1;
        end else if (w_dst_y < MY_Y_L) begin
            w_route[3] = 1'b1;
        end else begin
            w_route[4] = 1'b1;
        end
    end

    // Full means no push even when the head leaves this cycle.
    assign ready_o = (r_count < CW'(DEPTH));
    assign valid_o = (r_count != '0) ? w_route : 5'b00000;
    assign flit_o  = w_head;
    assign count_o = r_count;
    assign w_push  = valid_i && ready_o;
    assign w_pop   = |(valid_o & ready_i);

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= flit_i;
        end
    end

endmodule

// File: tb/tb_axi_grid_router_in_port.sv
// Bench for axi_grid_router_in_port: directed scenarios plus random traffic against a
// queue-based scoreboard with an XY route model.
module tb_axi_grid_router_in_port;

    localparam int unsigned X_W   = 4;
    localparam int unsigned Y_W   = 4;
    localparam int unsigned PW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MX    = 2;
    localparam int unsigned MY    = 2;
    localparam int unsigned FW    = X_W + Y_W + PW;

    logic          clk_i;
    logic          arst_ni;
    logic [FW-1:0] flit_i;
    logic          valid_i;
    logic          ready_o;
    logic [FW-1:0] flit_o;
    logic [4:0]    valid_o;
    logic [4:0]    ready_i;
    logic [2:0]    count_o;

    int checks = 0;
    int errors = 0;
    logic [FW-1:0] exp_q[$];

    axi_grid_router_in_port #(
        .X_W      (X_W),
        .Y_W      (Y_W),
        .PAYLOAD_W(PW),
        .DEPTH    (DEPTH),
        .MY_X     (MX),
        .MY_Y     (MY)
    ) dut (
        .clk_i  (clk_i),
        .arst_ni(arst_ni),
        .flit_i (flit_i),
        .valid_i(valid_i),
        .ready_o(ready_o),
        .flit_o (flit_o),
        .valid_o(valid_o),
        .ready_i(ready_i),
        .count_o(count_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Direction index 0..4 = E, W, N, S, L from plain integer comparisons.
    function automatic logic [4:0] route(input logic [FW-1:0] f);
        int dx;
        int dy;
        int dir;
        dx = int'(f[FW-1 -: X_W]);
        dy = int'(f[FW-X_W-1 -: Y_W]);
        if (dx > int'(MX))      dir = 0;
        else if (dx < int'(MX)) dir = 1;
        else if (dy > int'(MY)) dir = 2;
        else if (dy < int'(MY)) dir = 3;
        else                    dir = 4;
        return 5'(1 << dir);
    endfunction

    function automatic logic [FW-1:0] mk(input int x, input int y, input int p);
        return {X_W'(x), Y_W'(y), PW'(p)};
    endfunction

    // Monitor: sample mid-cycle, compare against scoreboard, retire accepted heads.
    initial begin
        forever begin
            @(negedge clk_i);
            check("count_o", 32'(count_o), 32'(exp_q.size()));
            check("ready_o", 32'(ready_o), 32'(exp_q.size() < DEPTH));
            check("valid_onehot0", 32'($onehot0(valid_o)), 32'd1);
            if (exp_q.size() > 0) begin
                check("valid_o_route", 32'(valid_o), 32'(route(exp_q[0])));
                check("flit_o", 32'(flit_o), 32'(exp_q[0]));
                if (|(valid_o & ready_i)) void'(exp_q.pop_front());
            end else begin
                check("valid_o_idle", 32'(valid_o), 32'd0);
            end
        end
    end

    // One cycle of stimulus, starting and ending just after a rising edge.
    task automatic step(input logic v, input logic [FW-1:0] f, input logic [4:0] r);
        logic acc;
        valid_i = v;
        flit_i  = f;
        ready_i = r;
        acc = v && ready_o;
        @(posedge clk_i);
        #1;
        if (acc) exp_q.push_back(f);
    endtask

    initial begin
        logic [FW-1:0] pat [5];
        arst_ni = 1'b0;
        valid_i = 1'b0;
        flit_i  = '0;
        ready_i = 5'b00000;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready_o", 32'(ready_o), 32'd1);
        check("rst_valid_o", 32'(valid_o), 32'd0);
        check("rst_count_o", 32'(count_o), 32'd0);
        arst_ni = 1'b1;

        // Route sequence E, W, N, S, L with all directions ready.
        pat[0] = mk(3, 0, 16'h1111);
        pat[1] = mk(1, 5, 16'h2222);
        pat[2] = mk(2, 4, 16'h3333);
        pat[3] = mk(2, 0, 16'h4444);
        pat[4] = mk(2, 2, 16'h5555);
        for (int i = 0; i < 5; i++) step(1'b1, pat[i], 5'b11111);
        repeat (3) step(1'b0, '0, 5'b11111);

        // Fill to full with outputs blocked; fifth push refused.
        for (int i = 0; i < 5; i++) step(1'b1, mk(i, 7, 16'hA000 + i), 5'b00000);
        check("full_count", 32'(count_o), 32'd4);
        check("full_ready", 32'(ready_o), 32'd0);
        repeat (6) step(1'b0, '0, 5'b11111);
        check("drain_count", 32'(count_o), 32'd0);

        // East head held while only other directions are ready.
        step(1'b1, mk(9, 9, 16'hBEEF), 5'b11110);
        repeat (3) step(1'b0, '0, 5'b11110);
        check("hold_valid", 32'(valid_o), 32'd1);
        check("hold_flit", 32'(flit_o), 32'(mk(9, 9, 16'hBEEF)));
        step(1'b0, '0, 5'b00001);
        check("hold_popped", 32'(count_o), 32'd0);

        // Simultaneous push/pop at 2, then at full.
        step(1'b1, mk(0, 1, 16'hC001), 5'b00000);
        step(1'b1, mk(0, 2, 16'hC002), 5'b00000);
        step(1'b1, mk(0, 3, 16'hC003), 5'b11111);
        check("pushpop_count", 32'(count_o), 32'd2);
        step(1'b1, mk(0, 4, 16'hC004), 5'b00000);
        step(1'b1, mk(0, 5, 16'hC005), 5'b00000);
        step(1'b1, mk(0, 6, 16'hC006), 5'b11111);
        check("full_pop_count", 32'(count_o), 32'd3);
        repeat (5) step(1'b0, '0, 5'b11111);

        // Asynchronous reset mid-cycle with three flits buffered.
        for (int i = 0; i < 3; i++) step(1'b1, mk(5, i, 16'hD000 + i), 5'b00000);
        valid_i = 1'b0;
        #1 arst_ni = 1'b0;
        #1;
        check("arst_count", 32'(count_o), 32'd0);
        check("arst_valid", 32'(valid_o), 32'd0);
        check("arst_ready", 32'(ready_o), 32'd1);
        #1 arst_ni = 1'b1;
        exp_q.delete();
        step(1'b1, mk(1, 1, 16'hE001), 5'b00000);
        check("post_rst_flit", 32'(flit_o), 32'(mk(1, 1, 16'hE001)));
        repeat (2) step(1'b0, '0, 5'b11111);

        // Random traffic.
        for (int i = 0; i < 1000; i++) begin
            step($urandom_range(0, 3) != 0, FW'($urandom), 5'($urandom));
        end
        repeat (8) step(1'b0, '0, 5'b11111);
        check("final_count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_grid_router_in_port.md
AXI_GRID_ROUTER_IN_PORT -- requirements
Module: axi_grid_router_in_port

Interface
REQ-001 SHALL have parameter X_W, default 4, width of grid X coordinate.
REQ-002 SHALL have parameter Y_W, default 4, width of grid Y coordinate.
REQ-003 SHALL have parameter PAYLOAD_W, default 64, non-routing flit bits.
REQ-004 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, >= 2.
REQ-005 SHALL have parameter MY_X, default 0, this router's X coordinate.
REQ-006 SHALL have parameter MY_Y, default 0, this router's Y coordinate.
REQ-007 SHALL derive FLIT_W = X_W+Y_W+PAYLOAD_W; flit layout {dst_x[MSBs], dst_y, payload[LSBs]}.
REQ-008 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-009 SHALL have port arst_ni  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-010 SHALL have port flit_i  input  FLIT_W  incoming flit from upstream network interface or neighbour link.
REQ-011 SHALL have port valid_i  input  1  flit_i valid.
REQ-012 SHALL have port ready_o  output  1  port can accept flit.
REQ-013 SHALL have port flit_o  output  FLIT_W  FIFO head flit, broadcast to all directions.
REQ-014 SHALL have port valid_o  output  5  one-hot request, bit order [0]=E [1]=W [2]=N [3]=S [4]=L(local).
REQ-015 SHALL have port ready_i  input  5  per-direction accept, same bit order.
REQ-016 SHALL have port count_o  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL accept (push) a flit on a rising edge when valid_i && ready_o.
REQ-018 SHALL drive ready_o = (count < DEPTH); no pass-through when full, even if a pop occurs the same cycle.
REQ-019 SHALL ignore flit_i whenever ready_o is 0; FIFO contents and count unchanged.
REQ-020 SHALL present a pushed flit on flit_o no earlier than the cycle after the push (latency 1 cycle, no combinational bypass).
REQ-021 SHALL compute route from head dst_x/dst_y by XY dimension order: dst_x>MY_X -> E; dst_x<MY_X -> W; else dst_y>MY_Y -> N; dst_y<MY_Y -> S; else L.
REQ-022 SHALL compare coordinates unsigned.
REQ-023 SHALL drive valid_o = one-hot(route) when count>0, else 5'b0; never more than one bit set.
REQ-024 SHALL pop the head on a rising edge when |(valid_o & ready_i); ready_i bits for non-selected directions have no effect.
REQ-025 SHALL hold flit_o and valid_o stable from assertion until accepted (no retraction).
REQ-026 SHALL on simultaneous push and pop (count between 1 and DEPTH-1) leave count unchanged and keep order.
REQ-027 SHALL on push only increment count by 1; on pop only decrement by 1.
REQ-028 SHALL keep write and read pointers of width $clog2(DEPTH), wrapping DEPTH-1 -> 0.
REQ-029 SHALL deliver flits strictly in arrival order, no loss, no duplication.
REQ-030 SHALL drive flit_o with don't-care contents when count==0; valid_o governs.

Reset
REQ-031 SHALL on arst_ni low asynchronously clear write pointer, read pointer and count to 0.
REQ-032 SHALL while in reset drive valid_o=5'b0, count_o=0, ready_o=1.
REQ-033 SHALL discard all buffered flits on reset asserted mid-operation; storage array need not be reset.
REQ-034 SHALL accept its first push on the first rising edge after arst_ni deasserts.

Verification
REQ-035 SHALL cover: MY_X=2,MY_Y=2; push dst (3,0),(1,5),(2,4),(2,0),(2,2) with all ready_i=1 -> valid_o sequence E,W,N,S,L, i.e. 5'b00001,00010,00100,01000,10000.
REQ-036 SHALL cover: DEPTH=4, ready_i=0, push 5 flits -> ready_o low after 4th, count_o=4, 5th ignored; then ready_i=5'b11111 -> 4 flits out in order, count_o returns to 0.
REQ-037 SHALL cover: head routed E, ready_i=5'b11110 for 3 cycles -> valid_o=5'b00001 and flit_o stable, no pop; ready_i[0]=1 -> pop next edge.
REQ-038 SHALL cover: count_o=2, push and pop same cycle -> count_o stays 2; at count_o=4 with pop and valid_i -> push refused, count_o becomes 3.
REQ-039 SHALL cover: 3 flits buffered, arst_ni pulsed low between edges -> count_o=0, valid_o=0 immediately; next pushed flit is first out.
REQ-040 SHALL cover: 1000-cycle random valid_i/ready_i against scoreboard -> order preserved, route matches XY model, valid_o one-hot or zero every cycle.
